// File: rtl/bloom_sett_master_if.sv
// Bloom-filter programming bus between the pattern-programming master and the search memory.
// Latency: none (wires only).
// Backpressure: the memory throttles writes with ready and signals full-clear completion with full_clr_done.
//   sett modport (master): drives wr_stb, hash, hash_mask_val, wr_data, full_clr_stb; samples ready, full_clr_done.
//   mem  modport (slave) : the mirror image.
interface bloom_setting_if #(
    parameter int HASH_CNT   = 10,
    parameter int HASH_WIDTH = 12
);
    logic                           wr_stb;
    logic [HASH_CNT*HASH_WIDTH-1:0] hash;
    logic [HASH_CNT-1:0]            hash_mask_val;
    logic                           wr_data;
    logic                           full_clr_stb;
    logic                           ready;
    logic                           full_clr_done;

    modport sett (
        output wr_stb, hash, hash_mask_val, wr_data, full_clr_stb,
        input  ready, full_clr_done
    );

    modport mem (
        input  wr_stb, hash, hash_mask_val, wr_data, full_clr_stb,
        output ready, full_clr_done
    );
endinterface

// File: rtl/bloom_sett_master.sv
// Sequences host SET/CLR/FULL_CLR commands onto the Bloom-filter programming bus.
// Latency: strobe 1 cycle after accept; done_o 1 cycle after the memory's ready / full_clr_done.
// Backpressure: cmd_ready_o only in IDLE with bsi.ready high; payload held until the write retires.
//   Ports: clk_i/rst_n_i (async active-low); cmd_* command handshake; done_o/busy_o/err_o/wr_cnt_o
//   status; err_clr_i clears sticky errors; bsi = bloom_setting_if.sett.
//   Optional watchdog on the wait states: define BLOOM_SETT_TIMEOUT_EN.
module bloom_sett_master #(
    parameter int HASH_CNT       = 10,
    parameter int HASH_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 8192,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           cmd_valid_i,
    output logic                           cmd_ready_o,
    input  logic [1:0]                     cmd_op_i,
    input  logic [HASH_CNT*HASH_WIDTH-1:0] cmd_hash_i,
    input  logic [HASH_CNT-1:0]            cmd_mask_i,
    output logic                           done_o,
    output logic                           busy_o,
    output logic [1:0]                     err_o,
    input  logic                           err_clr_i,
    output logic [CNT_WIDTH-1:0]           wr_cnt_o,
    bloom_setting_if.sett                  bsi
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_STB   = 3'd1,
        S_WR_WAIT  = 3'd2,
        S_CLR_STB  = 3'd3,
        S_CLR_WAIT = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic accept;
    logic in_wait;
    logic wr_done;
    logic clr_done;
    logic tmo_hit;
    logic tmo_exit;
    logic illegal;

    assign accept   = cmd_valid_i && cmd_ready_o;
    assign illegal  = accept && (cmd_op_i == 2'd3);
    assign in_wait  = (state == S_WR_WAIT) || (state == S_CLR_WAIT);
    assign wr_done  = (state == S_WR_WAIT) && bsi.ready;
    assign clr_done = (state == S_CLR_WAIT) && bsi.full_clr_done;
    // A real completion in the same cycle as the watchdog wins.
    assign tmo_exit = tmo_hit && !wr_done && !clr_done;

`ifdef BLOOM_SETT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Counts cycles spent in the current wait state; cleared whenever we leave it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)     tmo_cnt <= '0;
        else if (in_wait) tmo_cnt <= tmo_cnt + 1'b1;
        else              tmo_cnt <= '0;
    end

    // Fires on the TIMEOUT_CYCLES-th wait cycle, so the wait lasts exactly that long.
    assign tmo_hit = in_wait && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    // Watchdog compiled out: never fires (TIMEOUT_CYCLES is a positive count), waits are unbounded.
    assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (cmd_op_i)
                        2'd0, 2'd1: state_nxt = S_WR_STB;
                        2'd2:       state_nxt = S_CLR_STB;
                        default:    state_nxt = S_IDLE;
                    endcase
                end
            end
            S_WR_STB:   state_nxt = S_WR_WAIT;
            S_WR_WAIT:  if (wr_done || tmo_hit) state_nxt = S_IDLE;
            S_CLR_STB:  state_nxt = S_CLR_WAIT;
            S_CLR_WAIT: if (clr_done || tmo_hit) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        bsi.wr_stb       = (state == S_WR_STB);
        bsi.full_clr_stb = (state == S_CLR_STB);
        busy_o           = (state != S_IDLE);
        cmd_ready_o      = (state == S_IDLE) && bsi.ready;
    end

    // Write payload: captured on accept only, so it stays put until the write retires.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bsi.hash          <= '0;
            bsi.hash_mask_val <= '0;
            bsi.wr_data       <= 1'b0;
        end else if (accept && (cmd_op_i == 2'd0 || cmd_op_i == 2'd1)) begin
            bsi.hash          <= cmd_hash_i;
            bsi.hash_mask_val <= cmd_mask_i;
            bsi.wr_data       <= (cmd_op_i == 2'd0);
        end
    end

    // Retirement pulse, write counter and sticky errors
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            done_o   <= 1'b0;
            wr_cnt_o <= '0;
            err_o    <= 2'b00;
        end else begin
            done_o <= illegal || wr_done || clr_done || tmo_exit;

            if (clr_done)     wr_cnt_o <= '0;
            else if (wr_done) wr_cnt_o <= wr_cnt_o + 1'b1;

            if (err_clr_i) err_o <= 2'b00;
            else           err_o <= err_o | {illegal, tmo_exit};
        end
    end

endmodule

// File: tb/tb_bloom_sett_master.sv
// Self-checking bench for bloom_sett_master with a behavioural search-memory model.
// Memory model: ready drops after each wr_stb and returns rdly cycles after the strobe;
// full_clr_done drops after full_clr_stb and rises CLR_LEN+1 cycles later.
module tb_bloom_sett_master;
    localparam int HC      = 10;
    localparam int HW      = 12;
    localparam int TO      = 32;
    localparam int CW      = 16;
    localparam int CLR_LEN = 16;
    localparam int HBITS   = HC * HW;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'd0;
    logic [HBITS-1:0] cmd_hash = '0;
    logic [HC-1:0]    cmd_mask = '0;
    logic             done;
    logic             busy;
    logic [1:0]       err;
    logic             err_clr = 1'b0;
    logic [CW-1:0]    wr_cnt;

    always #5 clk = ~clk;

    bloom_setting_if #(.HASH_CNT(HC), .HASH_WIDTH(HW)) bsi ();

    bloom_sett_master #(
        .HASH_CNT(HC), .HASH_WIDTH(HW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_hash_i(cmd_hash), .cmd_mask_i(cmd_mask),
        .done_o(done), .busy_o(busy), .err_o(err), .err_clr_i(err_clr),
        .wr_cnt_o(wr_cnt), .bsi(bsi)
    );

    // ---------------- memory model ----------------
    int rdly  = 2;
    bit stuck = 1'b0;
    int rcnt;
    int ccnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bsi.ready         <= 1'b1;
            bsi.full_clr_done <= 1'b0;
            rcnt              <= 0;
            ccnt              <= 0;
        end else begin
            if (bsi.wr_stb) begin
                bsi.ready <= 1'b0;
                rcnt      <= rdly - 1;
            end else if (!bsi.ready && !stuck) begin
                if (rcnt <= 1) bsi.ready <= 1'b1;
                else           rcnt <= rcnt - 1;
            end
            if (bsi.full_clr_stb) begin
                bsi.full_clr_done <= 1'b0;
                ccnt              <= CLR_LEN;
            end else if (ccnt != 0) begin
                ccnt <= ccnt - 1;
                if (ccnt == 1) bsi.full_clr_done <= 1'b1;
            end
        end
    end

    // ---------------- reference state ----------------
    int            tests = 0;
    int            fails = 0;
    logic [CW-1:0] exp_cnt = '0;
    logic [1:0]    exp_err = 2'b00;

    // Per-command observations gathered by run_cmd
    bit acc_ok;
    int n_stb, n_fclr, n_done, done_c, n_pay_bad, n_rdy_bad, n_busy;

    function automatic logic [HBITS-1:0] rand_hash();
        logic [HBITS-1:0] h;
        for (int k = 0; k < HC; k++) h[k*HW +: HW] = HW'($urandom);
        return h;
    endfunction

    // Issue one command and watch the bus until two cycles after done_o (or budget).
    // Cycle c=1 is the cycle right after the accepting edge.
    task automatic run_cmd(input logic [1:0] op, input logic [HBITS-1:0] h,
                           input logic [HC-1:0] m, input int budget);
        int w;
        bit seen_stb;
        n_stb = 0; n_fclr = 0; n_done = 0; done_c = -1;
        n_pay_bad = 0; n_rdy_bad = 0; n_busy = 0; seen_stb = 1'b0;
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 1000) begin
            @(negedge clk);
            w++;
        end
        acc_ok = cmd_ready;
        if (!acc_ok) return;
        cmd_valid = 1'b1; cmd_op = op; cmd_hash = h; cmd_mask = m;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            if (bsi.wr_stb) begin n_stb++; seen_stb = 1'b1; end
            if (bsi.full_clr_stb) n_fclr++;
            if (busy) begin
                n_busy++;
                if (cmd_ready) n_rdy_bad++;
            end
            if (seen_stb && (busy || done) &&
                (bsi.hash !== h || bsi.hash_mask_val !== m || bsi.wr_data !== (op == 2'd0)))
                n_pay_bad++;
            if (done) begin
                n_done++;
                if (done_c < 0) done_c = c;
            end
            if (done_c > 0 && c >= done_c + 2) break;
            @(negedge clk);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({bsi.wr_stb, bsi.full_clr_stb, done, busy} !== 4'b0000) begin
            fails++; $display("FAIL reset_strobes: got %b want 0000", {bsi.wr_stb, bsi.full_clr_stb, done, busy});
        end
        tests++;
        if (err !== 2'b00 || wr_cnt !== '0) begin
            fails++; $display("FAIL reset_status: err=%b cnt=%0d want 0/0", err, wr_cnt);
        end
        tests++;
        if (bsi.hash !== '0 || bsi.hash_mask_val !== '0 || bsi.wr_data !== 1'b0) begin
            fails++; $display("FAIL reset_payload: nonzero payload, want all 0");
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++; $display("FAIL reset_ready: got %b want 1", cmd_ready);
        end
        exp_cnt = '0; exp_err = 2'b00;
    endtask

    task automatic test_set_basic();
        logic [HBITS-1:0] h;
        for (int k = 0; k < HC; k++) h[k*HW +: HW] = HW'(k * 3);
        rdly = 2;
        run_cmd(2'd0, h, 10'h3FF, 50);
        exp_cnt++;
        tests++;
        if (!acc_ok || n_stb != 1 || n_fclr != 0) begin
            fails++; $display("FAIL set_strobe: acc=%0d stb=%0d fclr=%0d want 1/1/0", acc_ok, n_stb, n_fclr);
        end
        tests++;
        if (n_pay_bad != 0 || bsi.wr_data !== 1'b1) begin
            fails++; $display("FAIL set_payload: bad=%0d wr_data=%b want 0/1", n_pay_bad, bsi.wr_data);
        end
        tests++;
        if (done_c != 4 || n_done != 1) begin
            fails++; $display("FAIL set_done: at=%0d count=%0d want 4/1", done_c, n_done);
        end
        tests++;
        if (wr_cnt !== exp_cnt) begin
            fails++; $display("FAIL set_cnt: got %0d want %0d", wr_cnt, exp_cnt);
        end
    endtask

    task automatic test_set_busy();
        logic [1:0] op;
        op = 2'($urandom_range(0, 1));
        rdly = 501;
        run_cmd(op, rand_hash(), HC'($urandom), 600);
        exp_cnt++;
        tests++;
        if (n_busy != rdly + 1 || n_rdy_bad != 0) begin
            fails++; $display("FAIL busy_hold: busy=%0d rdy_bad=%0d want %0d/0", n_busy, n_rdy_bad, rdly + 1);
        end
        tests++;
        if (n_pay_bad != 0 || n_stb != 1) begin
            fails++; $display("FAIL busy_payload: bad=%0d stb=%0d want 0/1", n_pay_bad, n_stb);
        end
        tests++;
        if (done_c != rdly + 2 || wr_cnt !== exp_cnt) begin
            fails++; $display("FAIL busy_retire: at=%0d cnt=%0d want %0d/%0d", done_c, wr_cnt, rdly + 2, exp_cnt);
        end
    endtask

    task automatic test_full_clr();
        for (int i = 0; i < 3; i++) begin
            rdly = $urandom_range(2, 5);
            run_cmd(2'($urandom_range(0, 1)), rand_hash(), HC'($urandom), 50);
            exp_cnt++;
            tests++;
            if (done_c != rdly + 2 || wr_cnt !== exp_cnt) begin
                fails++; $display("FAIL pre_clr_write: at=%0d cnt=%0d want %0d/%0d", done_c, wr_cnt, rdly + 2, exp_cnt);
            end
        end
        run_cmd(2'd2, '0, '0, 100);
        exp_cnt = '0;
        tests++;
        if (n_fclr != 1 || n_stb != 0 || n_done != 1) begin
            fails++; $display("FAIL clr_strobe: fclr=%0d stb=%0d done=%0d want 1/0/1", n_fclr, n_stb, n_done);
        end
        tests++;
        if (done_c != CLR_LEN + 3 || wr_cnt !== exp_cnt) begin
            fails++; $display("FAIL clr_done: at=%0d cnt=%0d want %0d/0", done_c, wr_cnt, CLR_LEN + 3);
        end
    endtask

    task automatic test_illegal_op();
        int w;
        run_cmd(2'd3, rand_hash(), HC'($urandom), 10);
        exp_err[1] = 1'b1;
        tests++;
        if (n_stb != 0 || n_fclr != 0 || n_busy != 0) begin
            fails++; $display("FAIL op3_bus: stb=%0d fclr=%0d busy=%0d want 0/0/0", n_stb, n_fclr, n_busy);
        end
        tests++;
        if (done_c != 1 || n_done != 1 || err !== exp_err) begin
            fails++; $display("FAIL op3_done: at=%0d n=%0d err=%b want 1/1/%b", done_c, n_done, err, exp_err);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_err = 2'b00;
        tests++;
        if (err !== exp_err) begin
            fails++; $display("FAIL err_clr: got %b want %b", err, exp_err);
        end
        // Clear and illegal op in the same cycle: clear wins.
        w = 0;
        while (!cmd_ready && w < 100) begin @(negedge clk); w++; end
        cmd_valid = 1'b1; cmd_op = 2'd3; err_clr = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; err_clr = 1'b0;
        tests++;
        if (err !== 2'b00 || done !== 1'b1) begin
            fails++; $display("FAIL clr_priority: err=%b done=%b want 00/1", err, done);
        end
    endtask

    task automatic test_timeout();
        int w;
        rdly = 2;
        stuck = 1'b1;
        run_cmd(2'd0, rand_hash(), HC'($urandom), 200);
`ifdef BLOOM_SETT_TIMEOUT_EN
        exp_err[0] = 1'b1;
        tests++;
        if (done_c != TO + 2 || n_busy != TO + 1) begin
            fails++; $display("FAIL tmo_len: done_at=%0d busy=%0d want %0d/%0d", done_c, n_busy, TO + 2, TO + 1);
        end
        tests++;
        if (err !== exp_err || wr_cnt !== exp_cnt || busy !== 1'b0) begin
            fails++; $display("FAIL tmo_state: err=%b cnt=%0d busy=%b want %b/%0d/0", err, wr_cnt, busy, exp_err, exp_cnt);
        end
        stuck = 1'b0;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_err = 2'b00;
`else
        tests++;
        if (done_c != -1 || busy !== 1'b1 || n_rdy_bad != 0) begin
            fails++; $display("FAIL no_tmo: done_at=%0d busy=%b rdy_bad=%0d want -1/1/0", done_c, busy, n_rdy_bad);
        end
        stuck = 1'b0;
        w = 0;
        while (!done && w < 20) begin @(negedge clk); w++; end
        exp_cnt++;
        tests++;
        if (done !== 1'b1 || wr_cnt !== exp_cnt || err !== exp_err) begin
            fails++; $display("FAIL late_retire: done=%b cnt=%0d err=%b want 1/%0d/%b", done, wr_cnt, err, exp_cnt, exp_err);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [HBITS-1:0] hb;
        logic [HC-1:0]    mb;
        logic [1:0]       ob;
        int w, stb_tot;
        bit hit;
        rdly = 2;
        hb = rand_hash(); mb = HC'($urandom); ob = 2'($urandom_range(0, 1));
        w = 0; stb_tot = 0; hit = 1'b0;
        @(negedge clk);
        while (!cmd_ready && w < 100) begin @(negedge clk); w++; end
        cmd_valid = 1'b1; cmd_op = 2'($urandom_range(0, 1)); cmd_hash = rand_hash(); cmd_mask = HC'($urandom);
        @(negedge clk);
        cmd_op = ob; cmd_hash = hb; cmd_mask = mb;
        for (int c = 1; c <= 20; c++) begin
            if (bsi.wr_stb) stb_tot++;
            if (done) begin hit = cmd_ready; break; end
            @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        exp_cnt = exp_cnt + 2;
        tests++;
        if (hit !== 1'b1 || stb_tot != 1) begin
            fails++; $display("FAIL b2b_accept: ready_at_done=%b stb=%0d want 1/1", hit, stb_tot);
        end
        w = 0;
        while (!done && w < 20) begin
            if (bsi.wr_stb) stb_tot++;
            @(negedge clk);
            w++;
        end
        tests++;
        if (done !== 1'b1 || stb_tot != 2 || wr_cnt !== exp_cnt) begin
            fails++; $display("FAIL b2b_retire: done=%b stb=%0d cnt=%0d want 1/2/%0d", done, stb_tot, wr_cnt, exp_cnt);
        end
        tests++;
        if (bsi.hash !== hb || bsi.hash_mask_val !== mb || bsi.wr_data !== (ob == 2'd0)) begin
            fails++; $display("FAIL b2b_payload: second command payload not on bus");
        end
    endtask

    task automatic test_random();
        logic [1:0]    op;
        logic [HC-1:0] m;
        for (int i = 0; i < 12; i++) begin
            op   = 2'($urandom_range(0, 3));
            m    = (i == 5) ? '0 : HC'($urandom);
            rdly = $urandom_range(2, 8);
            if (op == 2'd2 && ($urandom_range(0, 1) == 0)) op = 2'd1;
            run_cmd(op, rand_hash(), m, 60);
            if (op <= 2'd1) exp_cnt++;
            else if (op == 2'd2) exp_cnt = '0;
            else exp_err[1] = 1'b1;
            tests++;
            if (!acc_ok || n_done != 1 || n_pay_bad != 0 || wr_cnt !== exp_cnt || err !== exp_err) begin
                fails++; $display("FAIL rand_%0d op%0d: done=%0d bad=%0d cnt=%0d err=%b want 1/0/%0d/%b",
                                  i, op, n_done, n_pay_bad, wr_cnt, err, exp_cnt, exp_err);
            end
            if (op <= 2'd1) begin
                tests++;
                if (done_c != rdly + 2 || n_stb != 1) begin
                    fails++; $display("FAIL rand_lat_%0d: at=%0d stb=%0d want %0d/1", i, done_c, n_stb, rdly + 2);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int w;
        rdly = 3;
        run_cmd(2'd3, '0, '0, 10);
        run_cmd(2'd0, rand_hash(), HC'($urandom), 40);
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 100) begin @(negedge clk); w++; end
        cmd_valid = 1'b1; cmd_op = 2'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        tests++;
        if (busy !== 1'b1 || wr_cnt === '0 || err === 2'b00) begin
            fails++; $display("FAIL mid_pre: busy=%b cnt=%0d err=%b want 1/nonzero/nonzero", busy, wr_cnt, err);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({bsi.wr_stb, bsi.full_clr_stb, done, busy} !== 4'b0000 || err !== 2'b00 || wr_cnt !== '0) begin
            fails++; $display("FAIL mid_async: ctl=%b err=%b cnt=%0d want 0000/00/0",
                              {bsi.wr_stb, bsi.full_clr_stb, done, busy}, err, wr_cnt);
        end
        tests++;
        if (bsi.hash !== '0 || bsi.hash_mask_val !== '0 || bsi.wr_data !== 1'b0) begin
            fails++; $display("FAIL mid_payload: payload not cleared by reset");
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL mid_release: ready=%b busy=%b want 1/0", cmd_ready, busy);
        end
    endtask

    initial begin
        test_reset();
        test_set_basic();
        test_set_busy();
        test_full_clr();
        test_illegal_op();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
